// File: rtl/ap_ctrl_chain_driver.sv
// ap_ctrl_chain_driver
//
// Stimulus-side driver for the ap_ctrl_chain block-level handshake. A run is
// started with `go`; the driver then issues `num_trans` start handshakes to
// the DUT, keeps at most DEPTH of them outstanding, acknowledges completions
// with ap_continue and measures per-transaction latency. `finish` rises once
// every issued transaction has been acknowledged.
//
// Handshake semantics: a start transfer happens on the rising edge where
// ap_start && ap_ready are both high; ap_ready while ap_start is low is
// ignored. A completion transfer happens on the rising edge where
// ap_done && ap_continue are both high; the DUT holds ap_done until then.
//
// Ports:
//   clock, reset         sole clock (rising edge); async active-high reset
//   go, num_trans        start a run of num_trans transactions (IDLE/FINISH only)
//   continue_hold        forces ap_continue low (consumer back-pressure)
//   ap_ready, ap_done    DUT handshake inputs
//   ap_start, ap_continue DUT handshake outputs
//   busy, finish, err    run status (RUN/DRAIN, FINISH, sticky protocol error)
//   issued_cnt, done_cnt accepted starts / acknowledged dones this run
//   last_latency, max_latency, total_cycles  timing results
//   fsm_state            current FSM state for observation
module ap_ctrl_chain_driver #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [CNT_W-1:0] num_trans,
  input  logic             continue_hold,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_start,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic             err,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [TS_W-1:0]  last_latency,
  output logic [TS_W-1:0]  max_latency,
  output logic [TS_W-1:0]  total_cycles,
  output logic [1:0]       fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] DEPTH_V = OW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] n_lat;
  logic [OW-1:0]    outstanding;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [TS_W-1:0]  cycle_cnt;
  logic [TS_W-1:0]  run_cycles;
  logic [TS_W-1:0]  ts_mem [DEPTH];

  logic             active;
  logic             accept_go;
  logic             push;
  logic             done_ack;
  logic             fifo_empty;
  logic             pop;
  logic             bypass;
  logic             store;
  logic             spurious;
  logic             complete;
  logic [CNT_W-1:0] issued_next;
  logic [CNT_W-1:0] done_next;
  logic [TS_W-1:0]  lat_new;

  assign active      = (state == S_RUN) || (state == S_DRAIN);
  assign accept_go   = go && ((state == S_IDLE) || (state == S_FINISH));
  assign busy        = active;
  assign finish      = (state == S_FINISH);
  assign fsm_state   = state;

  // ap_start depends only on registered state, never on ap_ready.
  assign ap_start    = (state == S_RUN) && (issued_cnt < n_lat) && (outstanding < DEPTH_V);
  assign ap_continue = active && !continue_hold;

  assign push        = ap_start && ap_ready;
  assign done_ack    = ap_done && ap_continue;
  assign fifo_empty  = (outstanding == '0);
  assign pop         = done_ack && !fifo_empty;
  // A done arriving with an empty FIFO in the same cycle as a start pairs
  // with that start directly: nothing is stored, latency is zero.
  assign bypass      = done_ack && fifo_empty && push;
  assign store       = push && !bypass;
  assign spurious    = done_ack && fifo_empty && !push;
  assign complete    = pop || bypass;

  assign issued_next = issued_cnt + CNT_W'(push);
  assign done_next   = done_cnt + CNT_W'(complete);
  assign lat_new     = bypass ? '0 : (cycle_cnt - ts_mem[rd_ptr]);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_FINISH: begin
        if (accept_go) state_next = (num_trans == '0) ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        // The final completion can coincide with the final start (bypass).
        if (complete && (done_next == n_lat)) state_next = S_FINISH;
        else if (issued_next == n_lat)        state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (complete && (done_next == n_lat)) state_next = S_FINISH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      n_lat        <= '0;
      issued_cnt   <= '0;
      done_cnt     <= '0;
      outstanding  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cycle_cnt    <= '0;
      run_cycles   <= '0;
      last_latency <= '0;
      max_latency  <= '0;
      total_cycles <= '0;
      err          <= 1'b0;
    end else begin
      state <= state_next;
      if (accept_go) begin
        n_lat        <= num_trans;
        issued_cnt   <= '0;
        done_cnt     <= '0;
        outstanding  <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        cycle_cnt    <= '0;
        run_cycles   <= '0;
        last_latency <= '0;
        max_latency  <= '0;
        total_cycles <= '0;
        err          <= 1'b0;
      end else if (active) begin
        cycle_cnt  <= cycle_cnt + TS_W'(1);
        if (run_cycles != '1) run_cycles <= run_cycles + TS_W'(1);
        issued_cnt <= issued_next;
        done_cnt   <= done_next;
        if (store) wr_ptr <= wr_ptr + PW'(1);
        if (pop)   rd_ptr <= rd_ptr + PW'(1);
        outstanding <= outstanding + OW'(store) - OW'(pop);
        if (complete) begin
          last_latency <= lat_new;
          if (lat_new > max_latency) max_latency <= lat_new;
        end
        if (spurious) err <= 1'b1;
        // run_cycles excludes the current cycle, so add it on capture.
        if (state_next == S_FINISH) begin
          total_cycles <= (run_cycles == '1) ? run_cycles : (run_cycles + TS_W'(1));
        end
      end
    end
  end

  // Timestamp storage needs no reset: entries are only read once written.
  always_ff @(posedge clock) begin
    if (store) ts_mem[wr_ptr] <= cycle_cnt;
  end

endmodule
